// File: rtl/fft_mem_arb_pkg.sv
// fft_mem_arb_pkg
// Shared types and constants for the FFT sample-memory arbiter.
//   owner_e       : which requester currently holds locked ownership
//   REQ_CAP/FFT   : requester index, used for one-hot grant bits,
//                   last_grant and rd_owner encoding
//   *_DEFAULT     : default data / address widths (2048 x 10 bit memory)
package fft_mem_arb_pkg;

  localparam int NUM_BITS_DEFAULT  = 10;
  localparam int ADDR_BITS_DEFAULT = 11;

  localparam logic REQ_CAP = 1'b0;
  localparam logic REQ_FFT = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CAP  = 2'd1,
    OWN_FFT  = 2'd2
  } owner_e;

endpackage

// File: rtl/fft_mem_arbiter_if.sv
// fft_mem_arbiter_if
// Bundles both requester handshakes and the memory wrapper port.
//   cap_* / fft_* : req, lock, we, addr, wdata in; gnt, rvalid, rdata out
//   mem_*         : we, addr, din towards memory; dout back from memory
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and memory's view
interface fft_mem_arbiter_if
  import fft_mem_arb_pkg::*;
#(
  parameter int NUM_BITS  = NUM_BITS_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) ();

  logic                 cap_req;
  logic                 cap_lock;
  logic                 cap_we;
  logic [ADDR_BITS-1:0] cap_addr;
  logic [NUM_BITS-1:0]  cap_wdata;
  logic                 cap_gnt;
  logic                 cap_rvalid;
  logic [NUM_BITS-1:0]  cap_rdata;

  logic                 fft_req;
  logic                 fft_lock;
  logic                 fft_we;
  logic [ADDR_BITS-1:0] fft_addr;
  logic [NUM_BITS-1:0]  fft_wdata;
  logic                 fft_gnt;
  logic                 fft_rvalid;
  logic [NUM_BITS-1:0]  fft_rdata;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [NUM_BITS-1:0]  mem_din;
  logic [NUM_BITS-1:0]  mem_dout;

  modport slave (
    input  cap_req, cap_lock, cap_we, cap_addr, cap_wdata,
    output cap_gnt, cap_rvalid, cap_rdata,
    input  fft_req, fft_lock, fft_we, fft_addr, fft_wdata,
    output fft_gnt, fft_rvalid, fft_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cap_req, cap_lock, cap_we, cap_addr, cap_wdata,
    input  cap_gnt, cap_rvalid, cap_rdata,
    output fft_req, fft_lock, fft_we, fft_addr, fft_wdata,
    input  fft_gnt, fft_rvalid, fft_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/fft_mem_arb_pick.sv
// fft_mem_arb_pick
// Combinational two-way picker. Produces a one-hot grant (bit REQ_CAP /
// REQ_FFT) from the two requests, the current owner and, when
// FFT_MEM_ARB_RR_EN is defined, the last granted requester.
//   cap_req, fft_req : requests this cycle
//   owner            : registered owner state
//   last_grant       : (FFT_MEM_ARB_RR_EN only) index of last grantee
//   grant            : one-hot grant, at most one bit set
// Configuration macro: FFT_MEM_ARB_RR_EN selects round-robin conflict
// resolution; otherwise capture has fixed priority.
module fft_mem_arb_pick
  import fft_mem_arb_pkg::*;
(
  input  logic       cap_req,
  input  logic       fft_req,
  input  owner_e     owner,
`ifdef FFT_MEM_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // An owner that is still requesting is served exclusively. An owner that
  // drops its request has released the lock, so the same cycle falls
  // through to free arbitration and a waiting requester is not delayed.
  always_comb begin
    grant = 2'b00;
    if (owner == OWN_CAP && cap_req) begin
      grant[REQ_CAP] = 1'b1;
    end else if (owner == OWN_FFT && fft_req) begin
      grant[REQ_FFT] = 1'b1;
    end else if (cap_req && fft_req) begin
`ifdef FFT_MEM_ARB_RR_EN
      if (last_grant == REQ_CAP) begin
        grant[REQ_FFT] = 1'b1;
      end else begin
        grant[REQ_CAP] = 1'b1;
      end
`else
      grant[REQ_CAP] = 1'b1;
`endif
    end else if (cap_req) begin
      grant[REQ_CAP] = 1'b1;
    end else if (fft_req) begin
      grant[REQ_FFT] = 1'b1;
    end
  end

endmodule

// File: rtl/fft_mem_arbiter.sv
// fft_mem_arbiter
// Shares the single-port FFT sample memory (read latency 1) between the
// capture path and the FFT engine. Muxes the granted requester onto the
// memory port and routes read data back to whoever issued the read.
// Supports locked ownership for uninterrupted FFT bursts.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fft_mem_arbiter_if.slave (both requesters + memory port)
// Configuration macro: FFT_MEM_ARB_RR_EN enables round-robin arbitration
// with a last_grant register; undefined gives fixed capture priority.
module fft_mem_arbiter
  import fft_mem_arb_pkg::*;
#(
  parameter int NUM_BITS  = NUM_BITS_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  fft_mem_arbiter_if.slave bus
);

  owner_e               owner_q;
  owner_e               owner_d;
  logic [1:0]           pick_grant;
  logic [1:0]           grant;
  logic                 rd_pending_q;
  logic                 rd_owner_q;
  logic                 mem_we_c;
  logic [ADDR_BITS-1:0] mem_addr_c;
  logic [NUM_BITS-1:0]  mem_din_c;
`ifdef FFT_MEM_ARB_RR_EN
  logic                 last_grant_q;
`endif

  fft_mem_arb_pick u_pick (
    .cap_req    (bus.cap_req),
    .fft_req    (bus.fft_req),
    .owner      (owner_q),
`ifdef FFT_MEM_ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant      (pick_grant)
  );

  // Grants are suppressed for the whole time reset is held so nothing
  // reaches the memory while the arbiter state is being cleared.
  assign grant       = rst ? 2'b00 : pick_grant;
  assign bus.cap_gnt = grant[REQ_CAP];
  assign bus.fft_gnt = grant[REQ_FFT];

  // Memory port mux: the granted requester drives the port, an idle port
  // is held at zero.
  always_comb begin
    mem_we_c   = 1'b0;
    mem_addr_c = '0;
    mem_din_c  = '0;
    if (grant[REQ_CAP]) begin
      mem_we_c   = bus.cap_we;
      mem_addr_c = bus.cap_addr;
      mem_din_c  = bus.cap_wdata;
    end else if (grant[REQ_FFT]) begin
      mem_we_c   = bus.fft_we;
      mem_addr_c = bus.fft_addr;
      mem_din_c  = bus.fft_wdata;
    end
  end

  assign bus.mem_we   = mem_we_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_din  = mem_din_c;

  // Owner next state: a granted access with lock keeps (or takes) the
  // port for that requester; anything else, including an owner that
  // stopped requesting, returns to free arbitration.
  always_comb begin
    owner_d = OWN_NONE;
    if (grant[REQ_CAP] && bus.cap_lock) begin
      owner_d = OWN_CAP;
    end else if (grant[REQ_FFT] && bus.fft_lock) begin
      owner_d = OWN_FFT;
    end
  end

  // Owner register and read-return tracking. Reset discards any read in
  // flight so no stale rvalid appears once reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= REQ_CAP;
    end else begin
      owner_q      <= owner_d;
      rd_pending_q <= (|grant) && !mem_we_c;
      if (|grant) begin
        rd_owner_q <= grant[REQ_FFT];
      end
    end
  end

`ifdef FFT_MEM_ARB_RR_EN
  // Round-robin history: remembers who was served last, updated on every
  // grant whether or not there was a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_FFT;
    end else if (|grant) begin
      last_grant_q <= grant[REQ_FFT];
    end
  end
`endif

  // Read data goes only to the requester whose read was granted last
  // cycle; the other side sees zeros.
  assign bus.cap_rvalid = rd_pending_q && (rd_owner_q == REQ_CAP);
  assign bus.fft_rvalid = rd_pending_q && (rd_owner_q == REQ_FFT);
  assign bus.cap_rdata  = bus.cap_rvalid ? bus.mem_dout : '0;
  assign bus.fft_rdata  = bus.fft_rvalid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_fft_mem_arbiter.sv
// tb_fft_mem_arbiter
// Directed testbench for fft_mem_arbiter. Models the 2048 x 10 read-first
// single-port memory behind the arbiter and walks through reset, basic
// write/read routing, arbitration, locking, release, reset during a read
// and a 16-beat FFT read burst. Inputs change on the falling edge; outputs
// are sampled 1 time unit later.
// Configuration macro: FFT_MEM_ARB_RR_EN switches the expected grant
// pattern of the conflict test to round-robin.
module tb_fft_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [9:0] mem [0:2047];

  fft_mem_arbiter_if #(.NUM_BITS(10), .ADDR_BITS(11)) bus ();

  fft_mem_arbiter #(.NUM_BITS(10), .ADDR_BITS(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic set_cap(input logic req, input logic lock, input logic we,
                         input logic [10:0] addr, input logic [9:0] wdata);
    bus.cap_req = req; bus.cap_lock = lock; bus.cap_we = we;
    bus.cap_addr = addr; bus.cap_wdata = wdata;
  endtask

  task automatic set_fft(input logic req, input logic lock, input logic we,
                         input logic [10:0] addr, input logic [9:0] wdata);
    bus.fft_req = req; bus.fft_lock = lock; bus.fft_we = we;
    bus.fft_addr = addr; bus.fft_wdata = wdata;
  endtask

  task automatic idle_all();
    set_cap(1'b0, 1'b0, 1'b0, 11'd0, 10'd0);
    set_fft(1'b0, 1'b0, 1'b0, 11'd0, 10'd0);
  endtask

  // Reset holds all grants low even with both requesters active.
  task automatic test_reset();
    rst = 1'b1;
    set_cap(1'b1, 1'b1, 1'b1, 11'd3, 10'h0AA);
    set_fft(1'b1, 1'b1, 1'b1, 11'd4, 10'h0BB);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.cap_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_cap_gnt got=%0h exp=0", bus.cap_gnt); end
    checks++; if (bus.fft_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_fft_gnt got=%0h exp=0", bus.fft_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we got=%0h exp=0", bus.mem_we); end
    checks++; if (bus.cap_rvalid !== 1'b0 || bus.fft_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%0h/%0h exp=0/0", bus.cap_rvalid, bus.fft_rvalid); end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 11'd0 || bus.mem_din !== 10'd0) begin failures++; $display("[TB] FAIL idle_port got we=%0h addr=%0h din=%0h exp=0/0/0", bus.mem_we, bus.mem_addr, bus.mem_din); end
    checks++; if (bus.cap_gnt !== 1'b0 || bus.fft_gnt !== 1'b0) begin failures++; $display("[TB] FAIL idle_gnt got=%0h/%0h exp=0/0", bus.cap_gnt, bus.fft_gnt); end
  endtask

  // Capture writes 0x155 to address 5, FFT reads it back next cycle.
  task automatic test_write_read();
    @(negedge clk);
    set_cap(1'b1, 1'b0, 1'b1, 11'd5, 10'h155);
    #1;
    checks++; if (bus.cap_gnt !== 1'b1) begin failures++; $display("[TB] FAIL wr_cap_gnt got=%0h exp=1", bus.cap_gnt); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'd5 || bus.mem_din !== 10'h155) begin failures++; $display("[TB] FAIL wr_port got we=%0h addr=%0h din=%0h exp=1/5/155", bus.mem_we, bus.mem_addr, bus.mem_din); end
    @(negedge clk);
    set_cap(1'b0, 1'b0, 1'b0, 11'd0, 10'd0);
    set_fft(1'b1, 1'b0, 1'b0, 11'd5, 10'd0);
    #1;
    checks++; if (bus.fft_gnt !== 1'b1 || bus.cap_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rd_fft_gnt got fft=%0h cap=%0h exp=1/0", bus.fft_gnt, bus.cap_gnt); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 11'd5) begin failures++; $display("[TB] FAIL rd_port got we=%0h addr=%0h exp=0/5", bus.mem_we, bus.mem_addr); end
    checks++; if (bus.cap_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL write_no_rvalid got=%0h exp=0", bus.cap_rvalid); end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (bus.fft_rvalid !== 1'b1 || bus.fft_rdata !== 10'h155) begin failures++; $display("[TB] FAIL rd_return got v=%0h d=%0h exp=1/155", bus.fft_rvalid, bus.fft_rdata); end
    checks++; if (bus.cap_rvalid !== 1'b0 || bus.cap_rdata !== 10'd0) begin failures++; $display("[TB] FAIL rd_nonowner got v=%0h d=%0h exp=0/0", bus.cap_rvalid, bus.cap_rdata); end
    @(negedge clk); #1;
    checks++; if (bus.fft_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_single_rvalid got=%0h exp=0", bus.fft_rvalid); end
  endtask

  // Both requesters read every cycle without lock.
  task automatic test_conflict();
    logic exp_cap;
    logic prev_cap;
    prev_cap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_cap(1'b1, 1'b0, 1'b0, 11'd10, 10'd0);
      set_fft(1'b1, 1'b0, 1'b0, 11'd20, 10'd0);
      #1;
`ifdef FFT_MEM_ARB_RR_EN
      exp_cap = (i % 2 == 0);
`else
      exp_cap = 1'b1;
`endif
      checks++; if (bus.cap_gnt !== exp_cap || bus.fft_gnt !== !exp_cap) begin failures++; $display("[TB] FAIL conflict_gnt[%0d] got cap=%0h fft=%0h exp=%0h/%0h", i, bus.cap_gnt, bus.fft_gnt, exp_cap, !exp_cap); end
      if (i > 0) begin
        checks++; if (bus.cap_rvalid !== prev_cap || bus.fft_rvalid !== !prev_cap) begin failures++; $display("[TB] FAIL conflict_rvalid[%0d] got cap=%0h fft=%0h exp=%0h/%0h", i, bus.cap_rvalid, bus.fft_rvalid, prev_cap, !prev_cap); end
      end
      prev_cap = exp_cap;
    end
    @(negedge clk);
    idle_all();
  endtask

  // FFT locks for 4 reads, unlocks on the 5th; capture waits meanwhile.
  task automatic test_lock();
    @(negedge clk);
    set_fft(1'b1, 1'b1, 1'b0, 11'd100, 10'd0);
    #1;
    checks++; if (bus.fft_gnt !== 1'b1) begin failures++; $display("[TB] FAIL lock_take got=%0h exp=1", bus.fft_gnt); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      set_cap(1'b1, 1'b0, 1'b1, 11'd200, 10'h3FF);
      set_fft(1'b1, (i < 4), 1'b0, 11'(100 + i), 10'd0);
      #1;
      checks++; if (bus.cap_gnt !== 1'b0 || bus.fft_gnt !== 1'b1) begin failures++; $display("[TB] FAIL lock_hold[%0d] got cap=%0h fft=%0h exp=0/1", i, bus.cap_gnt, bus.fft_gnt); end
      checks++; if (bus.fft_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL lock_rvalid[%0d] got=%0h exp=1", i, bus.fft_rvalid); end
    end
    @(negedge clk);
    set_fft(1'b1, 1'b0, 1'b0, 11'd105, 10'd0);
    #1;
    checks++; if (bus.cap_gnt !== 1'b1 || bus.fft_gnt !== 1'b0) begin failures++; $display("[TB] FAIL lock_after got cap=%0h fft=%0h exp=1/0", bus.cap_gnt, bus.fft_gnt); end
    @(negedge clk);
    idle_all();
  endtask

  // FFT takes the lock then drops req; capture is served that same cycle.
  task automatic test_release();
    @(negedge clk);
    set_fft(1'b1, 1'b1, 1'b0, 11'd7, 10'd0);
    #1;
    checks++; if (bus.fft_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rel_take got=%0h exp=1", bus.fft_gnt); end
    @(negedge clk);
    set_fft(1'b0, 1'b0, 1'b0, 11'd0, 10'd0);
    set_cap(1'b1, 1'b0, 1'b0, 11'd5, 10'd0);
    #1;
    checks++; if (bus.cap_gnt !== 1'b1 || bus.mem_addr !== 11'd5) begin failures++; $display("[TB] FAIL rel_cap_gnt got gnt=%0h addr=%0h exp=1/5", bus.cap_gnt, bus.mem_addr); end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (bus.cap_rvalid !== 1'b1 || bus.cap_rdata !== 10'h155) begin failures++; $display("[TB] FAIL rel_cap_rdata got v=%0h d=%0h exp=1/155", bus.cap_rvalid, bus.cap_rdata); end
  endtask

  // Reset lands on the edge right after a locked FFT read is granted.
  task automatic test_reset_mid();
    @(negedge clk);
    set_fft(1'b1, 1'b1, 1'b0, 11'd5, 10'd0);
    #1;
    checks++; if (bus.fft_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rmid_gnt got=%0h exp=1", bus.fft_gnt); end
    @(posedge clk);
    rst = 1'b1;
    set_cap(1'b1, 1'b0, 1'b0, 11'd5, 10'd0);
    #1;
    checks++; if (bus.fft_rvalid !== 1'b0 || bus.cap_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_rvalid got=%0h/%0h exp=0/0", bus.fft_rvalid, bus.cap_rvalid); end
    @(negedge clk); #1;
    checks++; if (bus.cap_gnt !== 1'b0 || bus.fft_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rmid_gnt_in_reset got=%0h/%0h exp=0/0", bus.cap_gnt, bus.fft_gnt); end
    @(negedge clk);
    rst = 1'b0;
    set_fft(1'b1, 1'b0, 1'b0, 11'd7, 10'd0);
    #1;
    checks++; if (bus.fft_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_stale_rvalid got=%0h exp=0", bus.fft_rvalid); end
    checks++; if (bus.cap_gnt !== 1'b1 || bus.fft_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rmid_unlocked got cap=%0h fft=%0h exp=1/0", bus.cap_gnt, bus.fft_gnt); end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (bus.cap_rvalid !== 1'b1 || bus.cap_rdata !== 10'h155 || bus.fft_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_after got cap v=%0h d=%0h fft v=%0h exp=1/155/0", bus.cap_rvalid, bus.cap_rdata, bus.fft_rvalid); end
  endtask

  // Preload 0..15 with 0x2A0+addr, then 16 back-to-back locked FFT reads.
  task automatic test_back_to_back();
    int run;
    run = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_cap(1'b1, 1'b0, 1'b1, 11'(i), 10'(10'h2A0 + i));
      #1;
      checks++; if (bus.cap_gnt !== 1'b1) begin failures++; $display("[TB] FAIL preload_gnt[%0d] got=%0h exp=1", i, bus.cap_gnt); end
    end
    @(negedge clk);
    idle_all();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) set_fft(1'b1, (k < 15), 1'b0, 11'(k), 10'd0);
      else        set_fft(1'b0, 1'b0, 1'b0, 11'd0, 10'd0);
      #1;
      if (k < 16) begin
        checks++; if (bus.fft_gnt !== 1'b1) begin failures++; $display("[TB] FAIL burst_gnt[%0d] got=%0h exp=1", k, bus.fft_gnt); end
      end
      if (k > 0) begin
        if (bus.fft_rvalid === 1'b1) run++;
        checks++; if (bus.fft_rdata !== 10'(10'h2A0 + k - 1)) begin failures++; $display("[TB] FAIL burst_data[%0d] got=%0h exp=%0h", k - 1, bus.fft_rdata, 10'(10'h2A0 + k - 1)); end
      end
    end
    @(negedge clk); #1;
    checks++; if (run !== 16) begin failures++; $display("[TB] FAIL burst_run got=%0d exp=16", run); end
    checks++; if (bus.fft_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL burst_end_rvalid got=%0h exp=0", bus.fft_rvalid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_all();
    test_reset();
    test_write_read();
    test_conflict();
    test_lock();
    test_release();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
